// File: rtl/accel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | accel_pkg : shared widths, data type and saturation helper for the dense    |
// |             layer accelerator                                               |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
package accel_pkg;
  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int SAT_W  = 64;

  typedef logic [DATA_W-1:0] data_t;

  function automatic int acc_width(input int n);
    return PROD_W + $clog2(n + 1);
  endfunction

  function automatic data_t sat16(input logic [SAT_W-1:0] acc);
    return (|acc[SAT_W-1:DATA_W]) ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
  endfunction
endpackage
`default_nettype wire

// File: rtl/accelerator_neuron.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | neuron : one output of the dense layer -- registered products, then        |
// |          bias + sum with unsigned 16-bit saturation into the output reg     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module neuron
  import accel_pkg::*;
#(
  parameter int IN = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_inputs  [IN],
  input  logic [DATA_W-1:0] i_weights [IN],
  input  logic [DATA_W-1:0] i_bias,
  output logic [DATA_W-1:0] o_out
);
  localparam int ACC_W = acc_width(IN);

  logic [PROD_W-1:0] r_prod [IN];
  data_t             r_bias;
  data_t             r_out;
  logic [ACC_W-1:0]  w_acc;

  // Stage 1 registers are free-running; only the valid pipeline decides publication.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN; i++) begin
      r_prod[i] <= PROD_W'(i_inputs[i]) * PROD_W'(i_weights[i]);
    end
    r_bias <= i_bias;
  end

  always_comb begin
    w_acc = ACC_W'(r_bias);
    for (int i = 0; i < IN; i++) begin
      w_acc = w_acc + ACC_W'(r_prod[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (i_en) begin
      r_out <= sat16(SAT_W'(w_acc));
    end
  end

  assign o_out = r_out;
endmodule
`default_nettype wire

// File: rtl/accelerator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | accelerator : fully-connected layer, all outputs in parallel, 2-clock      |
// |               latency, one vector per clock                                 |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module accelerator
  import accel_pkg::*;
#(
  parameter int INPUT_NEURON_COUNT  = 15,
  parameter int OUTPUT_NEURON_COUNT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] inputs  [INPUT_NEURON_COUNT],
  input  logic [DATA_W-1:0] weights [OUTPUT_NEURON_COUNT*INPUT_NEURON_COUNT],
  input  logic [DATA_W-1:0] biases  [OUTPUT_NEURON_COUNT],
  output logic [DATA_W-1:0] out     [OUTPUT_NEURON_COUNT],
  output logic              out_valid
);
  localparam int IN  = INPUT_NEURON_COUNT;
  localparam int OUT = OUTPUT_NEURON_COUNT;

  logic r_v1;
  logic r_out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_v1        <= in_valid;
      r_out_valid <= r_v1;
    end
  end

  assign out_valid = r_out_valid;

  for (genvar o = 0; o < OUT; o++) begin : g_neuron
    data_t w_row [IN];

    for (genvar i = 0; i < IN; i++) begin : g_row
      assign w_row[i] = weights[o*IN + i];
    end

    neuron #(
      .IN(IN)
    ) u_neuron (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (r_v1),
      .i_inputs  (inputs),
      .i_weights (w_row),
      .i_bias    (biases[o]),
      .o_out     (out[o])
    );
  end
endmodule
`default_nettype wire

// File: tb/tb_accelerator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_accelerator : scoreboard bench for the dense layer accelerator          |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_accelerator;
  localparam int IN  = 15;
  localparam int OUT = 15;

  typedef logic [OUT*16-1:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] inputs  [IN];
  logic [15:0] weights [OUT*IN];
  logic [15:0] biases  [OUT];
  logic [15:0] out     [OUT];
  logic        out_valid;

  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  accelerator #(
    .INPUT_NEURON_COUNT (IN),
    .OUTPUT_NEURON_COUNT(OUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .inputs   (inputs),
    .weights  (weights),
    .biases   (biases),
    .out      (out),
    .out_valid(out_valid)
  );

  // Reference: plain wide-integer dot product, clamped to 16 bits.
  function automatic vec_t model();
    vec_t r;
    r = '0;
    for (int o = 0; o < OUT; o++) begin
      longint s;
      s = longint'(biases[o]);
      for (int i = 0; i < IN; i++) begin
        s += longint'(inputs[i]) * longint'(weights[o*IN + i]);
      end
      r[o*16 +: 16] = (s > 65535) ? 16'hFFFF : 16'(s);
    end
    return r;
  endfunction

  task automatic set_all(input logic [15:0] iv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < IN; i++) inputs[i] = iv;
    for (int k = 0; k < OUT*IN; k++) weights[k] = wv;
    for (int o = 0; o < OUT; o++) biases[o] = bv;
  endtask

  task automatic randomize_data(input bit wide);
    for (int i = 0; i < IN; i++) inputs[i] = wide ? 16'($urandom) : 16'($urandom_range(0, 255));
    for (int k = 0; k < OUT*IN; k++) weights[k] = wide ? 16'($urandom) : 16'($urandom_range(0, 255));
    for (int o = 0; o < OUT; o++) biases[o] = 16'($urandom);
  endtask

  task automatic drive(input bit v);
    in_valid = v;
    if (v) exp_q.push_back(model());
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // Monitor: checks every cycle once the first reset has been observed.
  initial begin
    bit   rs;
    bit   armed;
    vec_t got;
    vec_t last;
    vec_t e;
    armed = 1'b0;
    last  = '0;
    forever begin
      @(posedge clk);
      rs = rst_n;
      @(negedge clk);
      for (int o = 0; o < OUT; o++) got[o*16 +: 16] = out[o];
      if (!rs) begin
        armed = 1'b1;
        exp_q.delete();
        last = '0;
        tests++;
        if (out_valid !== 1'b0 || got !== '0) begin
          fails++;
          $display("FAIL reset: out_valid=%b out=%h required out_valid=0 out=0", out_valid, got);
        end
      end else if (armed) begin
        tests++;
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL spurious_valid: out_valid=1 out=%h required out_valid=0", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              fails++;
              $display("FAIL result: got %h required %h", got, e);
            end
            last = e;
          end
        end else if (out_valid !== 1'b0 || got !== last) begin
          fails++;
          $display("FAIL hold: out_valid=%b out=%h required out_valid=0 out=%h", out_valid, got, last);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d required 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    set_all(16'd0, 16'd0, 16'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Baseline: every neuron = 5 + 120 = 125
    for (int i = 0; i < IN; i++) inputs[i] = 16'(i + 1);
    for (int k = 0; k < OUT*IN; k++) weights[k] = 16'd1;
    for (int o = 0; o < OUT; o++) biases[o] = 16'd5;
    drive(1'b1);
    repeat (3) drive(1'b0);

    // Per-row weights: out[o] = 120*o
    for (int o = 0; o < OUT; o++) begin
      biases[o] = 16'd0;
      for (int i = 0; i < IN; i++) weights[o*IN + i] = 16'(o);
    end
    drive(1'b1);
    repeat (3) drive(1'b0);

    // Full saturation, then single-term saturation on neuron 0
    set_all(16'hFFFF, 16'hFFFF, 16'd1);
    drive(1'b1);
    repeat (3) drive(1'b0);
    set_all(16'd0, 16'd0, 16'd0);
    inputs[0]  = 16'd300;
    weights[0] = 16'd300;
    drive(1'b1);
    repeat (3) drive(1'b0);

    // Streaming: three back-to-back bias-only vectors
    set_all(16'd7, 16'd0, 16'd0);
    for (int k = 1; k <= 3; k++) begin
      for (int o = 0; o < OUT; o++) biases[o] = 16'(k);
      drive(1'b1);
    end
    repeat (4) drive(1'b0);

    // Reset while a vector is in flight
    randomize_data(1'b0);
    drive(1'b1);
    reset_pulse();
    repeat (4) drive(1'b0);

    // Idle with changing data: outputs must hold
    for (int n = 0; n < 6; n++) begin
      randomize_data(n[0]);
      drive(1'b0);
    end

    // Random traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      randomize_data($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 2) reset_pulse();
      else drive($urandom_range(0, 99) < 70);
    end

    repeat (5) drive(1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results pending, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
